// File: rtl/block_mem_burst_reader.sv
// block_mem_burst_reader: streams burst_len consecutive words starting at
// base_addr from a synchronous-read block RAM onto a valid/ready stream.
// A 2-entry skid buffer absorbs the 1-cycle RAM read latency.
// Optional feature macro: BMR_CHECKSUM_EN adds the cksum output.
module block_mem_burst_reader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024,
    parameter int LEN_W  = 11
) (
    input  logic              nested_clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  burst_len,
    output logic              busy,
    output logic              done,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready
`ifdef BMR_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] cksum
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [LEN_W-1:0]  DEPTH_L   = LEN_W'(DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);

    logic [1:0]              state_q, state_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [LEN_W-1:0]        rem_q, rem_d;
    logic                    infl_q, infl_d;
    logic                    infl_last_q, infl_last_d;
    logic [1:0][DATA_W-1:0]  buf_data_q, buf_data_d;
    logic [1:0]              buf_last_q, buf_last_d;
    logic                    wr_ptr_q, wr_ptr_d;
    logic                    rd_ptr_q, rd_ptr_d;
    logic [1:0]              cnt_q, cnt_d;
`ifdef BMR_CHECKSUM_EN
    logic [DATA_W-1:0]       cksum_q, cksum_d;
`endif

    logic issue;
    logic hs;
    logic push;
    logic pop;

    // Next-state logic: FSM, read issue, skid buffer and stream outputs.
    // While the buffer is empty the word returning from the RAM is presented
    // directly, so data reaches the stream the cycle it leaves the RAM; it is
    // captured into the buffer only if the consumer does not take it.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        rem_d       = rem_q;
        buf_data_d  = buf_data_q;
        buf_last_d  = buf_last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
`ifdef BMR_CHECKSUM_EN
        cksum_d     = cksum_q;
`endif

        issue = (state_q == S_READ) && (rem_q != '0) &&
                ((2'(infl_q) + cnt_q) < 2'd2);

        out_valid = (cnt_q != 2'd0) || infl_q;
        if (cnt_q != 2'd0) begin
            out_data = buf_data_q[rd_ptr_q];
            out_last = buf_last_q[rd_ptr_q];
        end else if (infl_q) begin
            out_data = mem_rdata;
            out_last = infl_last_q;
        end else begin
            out_data = '0;
            out_last = 1'b0;
        end

        hs   = out_valid && out_ready;
        push = infl_q && ((cnt_q != 2'd0) || !out_ready);
        pop  = hs && (cnt_q != 2'd0);

        if (push) begin
            buf_data_d[wr_ptr_q] = mem_rdata;
            buf_last_d[wr_ptr_q] = infl_last_q;
            wr_ptr_d             = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        cnt_d = cnt_q + 2'(push) - 2'(pop);

        infl_d      = issue;
        infl_last_d = issue && (rem_q == LEN_W'(1));
        if (issue) begin
            addr_d = (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_W'(1);
            rem_d  = rem_q - LEN_W'(1);
        end

`ifdef BMR_CHECKSUM_EN
        if (hs) begin
            cksum_d = cksum_q + out_data;
        end
`endif

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d = base_addr;
                    rem_d  = (burst_len > DEPTH_L) ? DEPTH_L : burst_len;
`ifdef BMR_CHECKSUM_EN
                    cksum_d = '0;
`endif
                    state_d = (burst_len == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                if (issue && (rem_q == LEN_W'(1))) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (hs && out_last) begin
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem_en   = issue;
    assign mem_addr = addr_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_DONE);
`ifdef BMR_CHECKSUM_EN
    assign cksum    = cksum_q;
`endif

    // State registers with synchronous reset; reset drops any buffered data.
    always_ff @(posedge nested_clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            rem_q       <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            buf_data_q  <= '0;
            buf_last_q  <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            cnt_q       <= 2'd0;
`ifdef BMR_CHECKSUM_EN
            cksum_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
            buf_data_q  <= buf_data_d;
            buf_last_q  <= buf_last_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
`ifdef BMR_CHECKSUM_EN
            cksum_q     <= cksum_d;
`endif
        end
    end

endmodule
